// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion controller.
// On each vsync falling edge every sprite is stepped by its signed velocity and
// bounced off the screen edges, one sprite per clock. The new positions are then
// published to the renderers in a single cycle, so a renderer never sees a half-updated frame.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a frame edge; config writes accepted
// ST_UPDATE  | stepping sprite idx through position/velocity update
// ST_PUBLISH | copying working positions/bounce to outputs, frame_done
module sprite_motion_ctrl #(
   parameter int N_SPRITES = 4,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int SPRITE_W  = 32,
   parameter int SPRITE_H  = 32,
   localparam int IW       = $clog2(N_SPRITES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   vsync,
   input  logic                   enable,
   input  logic                   cfg_we,
   input  logic [IW-1:0]          cfg_idx,
   input  logic [9:0]             cfg_x,
   input  logic [9:0]             cfg_y,
   input  logic [3:0]             cfg_vx,
   input  logic [3:0]             cfg_vy,
   output logic                   cfg_ready,
   output logic [10*N_SPRITES-1:0] sprite_x_flat,
   output logic [10*N_SPRITES-1:0] sprite_y_flat,
   output logic [N_SPRITES-1:0]   bounce,
   output logic                   busy,
   output logic                   frame_done
);

   localparam logic        [9:0]  X_MAX   = 10'(SCREEN_W - SPRITE_W);
   localparam logic        [9:0]  Y_MAX   = 10'(SCREEN_H - SPRITE_H);
   localparam logic signed [10:0] X_MAX_S = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0] Y_MAX_S = 11'(SCREEN_H - SPRITE_H);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_UPDATE  = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [IW-1:0] idx;
   logic          vs_d;
   logic          frame_edge;
   logic          frame_start;
   logic          last_idx;
   logic          cfg_hit;

   logic [9:0] x_w   [N_SPRITES];
   logic [9:0] y_w   [N_SPRITES];
   logic [3:0] vx_w  [N_SPRITES];
   logic [3:0] vy_w  [N_SPRITES];
   logic [9:0] x_pub [N_SPRITES];
   logic [9:0] y_pub [N_SPRITES];
   logic [N_SPRITES-1:0] bounce_w;

   logic signed [10:0] sx, sy;
   logic [9:0] x_nxt, y_nxt;
   logic [3:0] vx_nxt, vy_nxt;
   logic       bx, by;

   logic [9:0] cfg_x_c, cfg_y_c;
   logic [3:0] cfg_vx_c, cfg_vy_c;

   assign frame_edge  = vs_d & ~vsync;
   assign frame_start = frame_edge & enable & (state == ST_IDLE);
   assign last_idx    = (idx == IW'(N_SPRITES - 1));
   assign cfg_hit     = cfg_we & cfg_ready & ({1'b0, cfg_idx} < (IW+1)'(N_SPRITES));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; frame edges outside IDLE are dropped, not queued.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (frame_edge && enable) state_nxt = ST_UPDATE;
         ST_UPDATE:  if (last_idx)             state_nxt = ST_PUBLISH;
         ST_PUBLISH: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // FSM status outputs.
   always_comb begin
      busy      = (state != ST_IDLE);
      cfg_ready = (state == ST_IDLE);
   end

   // Step the current sprite: signed add, then clamp and reflect at either edge.
   always_comb begin
      sx     = $signed({1'b0, x_w[idx]}) + $signed({{7{vx_w[idx][3]}}, vx_w[idx]});
      sy     = $signed({1'b0, y_w[idx]}) + $signed({{7{vy_w[idx][3]}}, vy_w[idx]});
      x_nxt  = sx[9:0];
      vx_nxt = vx_w[idx];
      bx     = 1'b0;
      y_nxt  = sy[9:0];
      vy_nxt = vy_w[idx];
      by     = 1'b0;
      if (sx[10]) begin
         x_nxt = '0;    vx_nxt = -vx_w[idx]; bx = 1'b1;
      end else if (sx > X_MAX_S) begin
         x_nxt = X_MAX; vx_nxt = -vx_w[idx]; bx = 1'b1;
      end
      if (sy[10]) begin
         y_nxt = '0;    vy_nxt = -vy_w[idx]; by = 1'b1;
      end else if (sy > Y_MAX_S) begin
         y_nxt = Y_MAX; vy_nxt = -vy_w[idx]; by = 1'b1;
      end
   end

   // Sanitise config values: clamp positions on screen, and store -8 as -7 so that negating the velocity cannot overflow.
   always_comb begin
      cfg_x_c  = (cfg_x > X_MAX) ? X_MAX : cfg_x;
      cfg_y_c  = (cfg_y > Y_MAX) ? Y_MAX : cfg_y;
      cfg_vx_c = (cfg_vx == 4'b1000) ? 4'b1001 : cfg_vx;
      cfg_vy_c = (cfg_vy == 4'b1000) ? 4'b1001 : cfg_vy;
   end

   // Datapath: edge detect, config writes, per-sprite update, atomic publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_d       <= 1'b1;
         idx        <= '0;
         bounce_w   <= '0;
         bounce     <= '0;
         frame_done <= 1'b0;
         for (int i = 0; i < N_SPRITES; i++) begin
            x_w[i]   <= '0;
            y_w[i]   <= '0;
            vx_w[i]  <= '0;
            vy_w[i]  <= '0;
            x_pub[i] <= '0;
            y_pub[i] <= '0;
         end
      end else begin
         vs_d       <= vsync;
         frame_done <= 1'b0;
         if (cfg_hit) begin
            x_w[cfg_idx]   <= cfg_x_c;
            y_w[cfg_idx]   <= cfg_y_c;
            vx_w[cfg_idx]  <= cfg_vx_c;
            vy_w[cfg_idx]  <= cfg_vy_c;
            x_pub[cfg_idx] <= cfg_x_c;
            y_pub[cfg_idx] <= cfg_y_c;
         end
         if (frame_start) begin
            idx      <= '0;
            bounce_w <= '0;
         end
         if (state == ST_UPDATE) begin
            x_w[idx]      <= x_nxt;
            y_w[idx]      <= y_nxt;
            vx_w[idx]     <= vx_nxt;
            vy_w[idx]     <= vy_nxt;
            bounce_w[idx] <= bx | by;
            if (!last_idx) idx <= idx + 1'b1;
         end
         if (state == ST_PUBLISH) begin
            x_pub      <= x_w;
            y_pub      <= y_w;
            bounce     <= bounce_w;
            frame_done <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_SPRITES; g++) begin : g_flat
      assign sprite_x_flat[10*g +: 10] = x_pub[g];
      assign sprite_y_flat[10*g +: 10] = y_pub[g];
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed frames plus random config/frame traffic,
// scored against an integer model of sprite motion.
module tb_sprite_motion_ctrl;

   localparam int N  = 4;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int PW = 32;
   localparam int PH = 32;
   localparam int IW = $clog2(N);
   localparam int XM = SW - PW;
   localparam int YM = SH - PH;

   logic clk = 1'b0;
   logic reset, vsync, enable, cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [9:0] cfg_x, cfg_y;
   logic [3:0] cfg_vx, cfg_vy;
   logic cfg_ready, busy, frame_done;
   logic [10*N-1:0] sprite_x_flat, sprite_y_flat;
   logic [N-1:0] bounce;

   sprite_motion_ctrl #(.N_SPRITES(N), .SCREEN_W(SW), .SCREEN_H(SH),
                        .SPRITE_W(PW), .SPRITE_H(PH)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
      .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_ready(cfg_ready),
      .sprite_x_flat(sprite_x_flat), .sprite_y_flat(sprite_y_flat),
      .bounce(bounce), .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [10*N-1:0] x;
      logic [10*N-1:0] y;
      logic [N-1:0]    b;
      int              cyc;
   } exp_t;
   exp_t q[$];

   // model state: plain integers, velocities in -7..7
   int mx[N], my[N], mvx[N], mvy[N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(int v, int mx_v);
      return (v > mx_v) ? mx_v : v;
   endfunction

   function automatic int vel(int v);
      return (v == -8) ? -7 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
      end
   endtask

   task automatic model_write(int i, int x, int y, int vx, int vy);
      mx[i] = clampi(x, XM);  my[i] = clampi(y, YM);
      mvx[i] = vel(vx);       mvy[i] = vel(vy);
   endtask

   task automatic move(inout int p, inout int v, input int lim, output bit b);
      int s;
      s = p + v;
      b = 1'b0;
      if (s < 0)        begin p = 0;   v = -v; b = 1'b1; end
      else if (s > lim) begin p = lim; v = -v; b = 1'b1; end
      else              p = s;
   endtask

   function automatic logic [10*N-1:0] pack(input int a[N]);
      logic [10*N-1:0] r;
      for (int i = 0; i < N; i++) r[10*i +: 10] = 10'(a[i]);
      return r;
   endfunction

   task automatic model_frame(input int start_cyc);
      exp_t e;
      bit bxx, byy;
      e.b = '0;
      for (int i = 0; i < N; i++) begin
         move(mx[i], mvx[i], XM, bxx);
         move(my[i], mvy[i], YM, byy);
         e.b[i] = bxx | byy;
      end
      e.x = pack(mx);
      e.y = pack(my);
      e.cyc = start_cyc + N + 2;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive_cfg(int i, int x, int y, int vx, int vy);
      cfg_idx = IW'(i); cfg_x = 10'(x); cfg_y = 10'(y);
      cfg_vx = 4'(vx);  cfg_vy = 4'(vy);
   endtask

   task automatic cfg_write(int i, int x, int y, int vx, int vy);
      drive_cfg(i, x, y, vx, vy);
      cfg_we = 1'b1;
      model_write(i, x, y, vx, vy);
      tick();
      cfg_we = 1'b0;
      chk("cfg_pub_x", 64'(sprite_x_flat[10*i +: 10]), 64'(mx[i]));
      chk("cfg_pub_y", 64'(sprite_y_flat[10*i +: 10]), 64'(my[i]));
   endtask

   // co: caller has already driven cfg and updated the model; the write fires with the edge.
   // bw: attempt a config write while the frame is busy; it must be ignored.
   task automatic frame(bit en, bit co, bit bw);
      enable = en;
      if (co) cfg_we = 1'b1;
      if (en) model_frame(cyc);
      vsync = 1'b0;
      tick();
      cfg_we = 1'b0;
      vsync = 1'b1;
      if (en && bw) begin
         chk("busy_during_frame", 64'(busy), 64'd1);
         chk("cfg_ready_when_busy", 64'(cfg_ready), 64'd0);
         drive_cfg($urandom_range(0, N-1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                   $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8);
         cfg_we = 1'b1;
         tick();
         cfg_we = 1'b0;
      end
      for (int k = 0; k < N + 2 - ((en && bw) ? 1 : 0); k++) begin
         tick();
         if (!en) chk("busy_while_disabled", 64'(busy), 64'd0);
      end
      if (en) chk("frame_timeout_queue_empty", 64'(q.size()), 64'd0);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   int busy_run = 0;
   always @(negedge clk) begin
      if (reset) begin
         busy_run = 0;
      end else begin
         chk("cfg_ready_is_not_busy", 64'(cfg_ready), 64'(!busy));
         if (busy) busy_run++;
         else if (busy_run != 0) begin
            chk("busy_length", 64'(busy_run), 64'(N + 1));
            busy_run = 0;
         end
         if (frame_done === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_frame_done", 64'(frame_done), 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("frame_done_cycle", 64'(cyc), 64'(e.cyc));
               chk("pub_x", 64'(sprite_x_flat), 64'(e.x));
               chk("pub_y", 64'(sprite_y_flat), 64'(e.y));
               chk("bounce", 64'(bounce), 64'(e.b));
            end
         end
      end
   end

   initial begin
      reset = 1'b1; vsync = 1'b1; enable = 1'b0; cfg_we = 1'b0;
      drive_cfg(0, 0, 0, 0, 0);
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_x", 64'(sprite_x_flat), 64'd0);
      chk("rst_y", 64'(sprite_y_flat), 64'd0);
      chk("rst_bounce", 64'(bounce), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);

      // frozen: edges with enable low do nothing
      repeat (3) frame(1'b0, 1'b0, 1'b0);

      cfg_write(1, 100, 50, 3, -2);
      frame(1'b1, 1'b0, 1'b0);
      chk("s1_x_103", 64'(sprite_x_flat[19:10]), 64'd103);
      chk("s1_y_48", 64'(sprite_y_flat[19:10]), 64'd48);

      // right edge bounce then move back
      cfg_write(0, 606, 0, 5, 0);
      frame(1'b1, 1'b0, 1'b0);
      chk("s0_x_608", 64'(sprite_x_flat[9:0]), 64'd608);
      chk("s0_bounce", 64'(bounce[0]), 64'd1);
      frame(1'b1, 1'b0, 1'b0);
      chk("s0_x_603", 64'(sprite_x_flat[9:0]), 64'd603);
      chk("s0_no_bounce", 64'(bounce[0]), 64'd0);

      // top edge bounce with -8 velocity stored as -7
      cfg_write(2, 300, 1, -8, -4);
      frame(1'b1, 1'b0, 1'b0);
      chk("s2_y_0", 64'(sprite_y_flat[29:20]), 64'd0);
      chk("s2_x_293", 64'(sprite_x_flat[29:20]), 64'd293);
      chk("s2_bounce", 64'(bounce[2]), 64'd1);
      frame(1'b1, 1'b0, 1'b0);
      chk("s2_x_286", 64'(sprite_x_flat[29:20]), 64'd286);
      chk("s2_y_4", 64'(sprite_y_flat[29:20]), 64'd4);

      // write while busy ignored; write coincident with edge applied first
      enable = 1'b1;
      frame(1'b1, 1'b0, 1'b1);
      drive_cfg(3, 700, 470, 7, -8);
      model_write(3, 700, 470, 7, -8);
      frame(1'b1, 1'b1, 1'b0);
      chk("s3_coincident_x", 64'(sprite_x_flat[39:30]), 64'd608);
      chk("s3_coincident_y", 64'(sprite_y_flat[39:30]), 64'd441);

      // random traffic
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 5);
         if (r <= 1) begin
            cfg_write($urandom_range(0, N-1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8);
         end else if (r == 2) begin
            frame(1'b0, 1'b0, 1'b0);
         end else if (r == 3) begin
            int ri, rx, ry, rvx, rvy;
            ri = $urandom_range(0, N-1); rx = $urandom_range(0, 1023); ry = $urandom_range(0, 1023);
            rvx = $urandom_range(0, 15) - 8; rvy = $urandom_range(0, 15) - 8;
            drive_cfg(ri, rx, ry, rvx, rvy);
            model_write(ri, rx, ry, rvx, rvy);
            frame(1'b1, 1'b1, 1'b0);
         end else begin
            frame(1'b1, 1'b0, ($urandom_range(0, 1) == 1));
         end
      end

      // reset in the middle of UPDATE
      enable = 1'b1;
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      q.delete();
      model_reset();
      tick();
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_x", 64'(sprite_x_flat), 64'd0);
      chk("midrst_y", 64'(sprite_y_flat), 64'd0);
      chk("midrst_bounce", 64'(bounce), 64'd0);
      chk("midrst_frame_done", 64'(frame_done), 64'd0);
      reset = 1'b0;
      repeat (N + 3) tick();
      cfg_write(0, 700, 10, 0, 0);
      chk("clamp_x_608", 64'(sprite_x_flat[9:0]), 64'd608);
      frame(1'b1, 1'b0, 1'b0);
      chk("clamp_still_608", 64'(sprite_x_flat[9:0]), 64'd608);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
